regfile_wb_scoreboard: RTL and testbench

//  Architectural register file for the RISC-V pipeline, plus a pending-write scoreboard.

---
 rtl/regfile_wb_scoreboard_pkg.sv | 21 ++
 rtl/regfile_wb_scoreboard_sb.sv | 80 ++++++++
 rtl/regfile_wb_scoreboard.sv | 72 +++++++
 tb/tb_regfile_wb_scoreboard.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared constants and helpers for the register file / write-back scoreboard.
// Optional write-through forwarding is enabled by defining WB_BYPASS_EN.
package regfile_wb_scoreboard_pkg;

  localparam int unsigned D_BITS_DEF   = 32;
  localparam int unsigned A_BITS_DEF   = 5;
  localparam int unsigned NREGS_DEF    = 32;
  localparam int unsigned KILL_AGE_DEF = 2;
  localparam int unsigned REG_ZERO     = 0;
  localparam int unsigned AGE_BITS     = 2;

  typedef logic [AGE_BITS-1:0] age_t;

  localparam age_t AGE_MAX = '1;

  // Saturating age increment: an old entry stays at the maximum age.
  function automatic age_t age_sat_inc(input age_t a);
    return (a == AGE_MAX) ? a : a + AGE_BITS'(1);
  endfunction

endpackage

// File: rtl/regfile_wb_scoreboard_sb.sv
// Pending-write scoreboard: per-register busy/age tracking, flush kill and hazard detect.
// With WB_BYPASS_EN defined, a same-cycle commit hides the busy bit from the hazard check.
module regfile_wb_scoreboard_sb
  import regfile_wb_scoreboard_pkg::*;
#(
  parameter int unsigned A_BITS   = A_BITS_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned KILL_AGE = KILL_AGE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [A_BITS-1:0] wb_addr,
  input  logic [A_BITS-1:0] rd_addr1,
  input  logic [A_BITS-1:0] rd_addr2,
  input  logic              issue_valid,
  input  logic [A_BITS-1:0] issue_rd,
  input  logic              issue_we,
  input  logic              clr_sgn,
  output logic              issue_stall,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_eff;
  logic             accept;

  assign issue_stall = issue_valid &&
                       (busy_eff[rd_addr1] || busy_eff[rd_addr2] ||
                        (issue_we && busy_eff[issue_rd]));

  // A flush cycle never allocates, even when decode is otherwise clear to go.
  assign accept = issue_valid && !issue_stall && !clr_sgn && issue_we &&
                  (issue_rd != A_BITS'(REG_ZERO));

  for (genvar g = 0; g < NREGS; g++) begin : g_ent
    logic busy_q;
    logic busy_n;
    age_t age_q;
    age_t age_n;
    logic commit_hit;
    logic accept_hit;
    logic kill;

    always_comb begin
      busy_n     = busy_q;
      age_n      = '0;
      commit_hit = wb_valid && (wb_addr == A_BITS'(g)) && (g != 0);
      accept_hit = accept && (issue_rd == A_BITS'(g));
      kill       = clr_sgn && busy_q && (32'(age_q) < KILL_AGE);
      // Allocation beats a same-cycle commit or kill of the same register.
      if (accept_hit) begin
        busy_n = 1'b1;
        age_n  = '0;
      end else if (commit_hit || kill) begin
        busy_n = 1'b0;
        age_n  = '0;
      end else if (busy_q) begin
        age_n  = age_sat_inc(age_q);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        busy_q <= 1'b0;
        age_q  <= '0;
      end else begin
        busy_q <= busy_n;
        age_q  <= age_n;
      end
    end

    assign busy_vec[g] = busy_q;
`ifdef WB_BYPASS_EN
    assign busy_eff[g] = busy_q && !(wb_valid && (wb_addr == A_BITS'(g)));
`else
    assign busy_eff[g] = busy_q;
`endif
  end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Architectural register file with two combinational read ports and a pending-write scoreboard.
// Defining WB_BYPASS_EN forwards the committing write-back value to the read ports.
module regfile_wb_scoreboard
  import regfile_wb_scoreboard_pkg::*;
#(
  parameter int unsigned D_BITS   = D_BITS_DEF,
  parameter int unsigned A_BITS   = A_BITS_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned KILL_AGE = KILL_AGE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [A_BITS-1:0] wb_addr,
  input  logic [D_BITS-1:0] wb_data,
  input  logic [A_BITS-1:0] rd_addr1,
  input  logic [A_BITS-1:0] rd_addr2,
  output logic [D_BITS-1:0] rd_data1,
  output logic [D_BITS-1:0] rd_data2,
  input  logic              issue_valid,
  input  logic [A_BITS-1:0] issue_rd,
  input  logic              issue_we,
  output logic              issue_stall,
  input  logic              clr_sgn,
  output logic [NREGS-1:0]  busy_vec
);

  logic [D_BITS-1:0] regs [NREGS];

  // x0 has no write enable, so it holds its reset value of zero forever.
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    logic [D_BITS-1:0] q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if ((g != 0) && wb_valid && (wb_addr == A_BITS'(g))) begin
        q <= wb_data;
      end
    end
    assign regs[g] = q;
  end

`ifdef WB_BYPASS_EN
  logic wb_live;
  assign wb_live  = wb_valid && (wb_addr != A_BITS'(REG_ZERO));
  assign rd_data1 = (wb_live && (wb_addr == rd_addr1)) ? wb_data : regs[rd_addr1];
  assign rd_data2 = (wb_live && (wb_addr == rd_addr2)) ? wb_data : regs[rd_addr2];
`else
  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];
`endif

  regfile_wb_scoreboard_sb #(
    .A_BITS  (A_BITS),
    .NREGS   (NREGS),
    .KILL_AGE(KILL_AGE)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_we   (issue_we),
    .clr_sgn    (clr_sgn),
    .issue_stall(issue_stall),
    .busy_vec   (busy_vec)
  );

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against a timestamp-based model.
module tb_regfile_wb_scoreboard;

  localparam int KILL_AGE = 2;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_we;
  logic        issue_stall;
  logic        clr_sgn;
  logic [31:0] busy_vec;

  regfile_wb_scoreboard dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
    .issue_stall(issue_stall), .clr_sgn(clr_sgn), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Model: register values, busy flags and the cycle each entry was allocated.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          m_alloc[32];
  int          cyc;
  int          n_chk;
  int          n_fail;

  function automatic int m_age(input int r);
    int a;
    if (!m_busy[r]) return 0;
    a = cyc - m_alloc[r];
    return (a > 3) ? 3 : a;
  endfunction

  function automatic bit m_busy_eff(input logic [4:0] r);
    return m_busy[r] && !(BYP && wb_valid && wb_addr == r);
  endfunction

  function automatic bit m_stall();
    return issue_valid && (m_busy_eff(rd_addr1) || m_busy_eff(rd_addr2) ||
                           (issue_we && m_busy_eff(issue_rd)));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && wb_valid && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) begin
      m_regs[r]  = 32'h0;
      m_busy[r]  = 1'b0;
      m_alloc[r] = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; issue_valid = 1'b0; issue_rd = '0;
    issue_we = 1'b0; clr_sgn = 1'b0;
  endtask

  task automatic at_neg();
    @(negedge clk);
    idle_inputs();
  endtask

  // Inputs are settled: compare every observable output against the model.
  task automatic settle();
    if (rst) m_clear();
    #1;
    chk("issue_stall", 32'(issue_stall), 32'(m_stall()));
    chk("rd_data1", rd_data1, m_read(rd_addr1));
    chk("rd_data2", rd_data2, m_read(rd_addr2));
    chk("busy_vec", busy_vec, m_busy_vec());
  endtask

  // Advance the model across the rising edge using the inputs presented this cycle.
  task automatic tick();
    bit acc;
    @(posedge clk);
    if (rst) begin
      m_clear();
    end else begin
      acc = issue_valid && !m_stall() && !clr_sgn && issue_we && issue_rd != 5'd0;
      if (clr_sgn)
        for (int r = 0; r < 32; r++)
          if (m_busy[r] && m_age(r) < KILL_AGE) m_busy[r] = 1'b0;
      if (wb_valid && wb_addr != 5'd0) begin
        m_regs[wb_addr] = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      cyc++;
      if (acc) begin
        m_busy[issue_rd]  = 1'b1;
        m_alloc[issue_rd] = cyc;
      end
    end
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd;
  endtask

  task automatic commit(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    m_clear();
    idle_inputs();
    rst = 1'b1;

    // Reset, then every register reads zero.
    at_neg(); rst = 1'b1; settle(); tick();
    for (int i = 0; i < 32; i++) begin
      at_neg(); rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i); settle();
      chk("reset_read1", rd_data1, 32'h0);
      chk("reset_read2", rd_data2, 32'h0);
      tick();
    end
    chk("reset_busy", busy_vec, 32'h0);
    chk("reset_stall", 32'(issue_stall), 32'h0);

    // Commit and read back; x0 ignores writes.
    at_neg(); commit(5'd5, 32'hDEADBEEF); settle(); tick();
    at_neg(); rd_addr1 = 5'd5; settle();
    chk("x5_read", rd_data1, 32'hDEADBEEF);
    tick();
    at_neg(); commit(5'd0, 32'h1234); settle(); tick();
    at_neg(); rd_addr1 = 5'd0; settle();
    chk("x0_read", rd_data1, 32'h0);
    tick();

    // RAW on x7 resolved by its commit.
    at_neg(); issue(5'd7); settle(); tick();
    at_neg(); issue_valid = 1'b1; rd_addr1 = 5'd7; settle();
    chk("raw_stall", 32'(issue_stall), 32'h1);
    tick();
    at_neg(); issue_valid = 1'b1; rd_addr1 = 5'd7; commit(5'd7, 32'h55); settle();
    chk("commit_cycle_stall", 32'(issue_stall), BYP ? 32'h0 : 32'h1);
    if (BYP) chk("bypass_data", rd_data1, 32'h55);
    tick();
    at_neg(); issue_valid = 1'b1; rd_addr1 = 5'd7; settle();
    chk("post_commit_stall", 32'(issue_stall), 32'h0);
    chk("post_commit_data", rd_data1, 32'h55);
    tick();

    // Flush kills the young x4 entry but keeps the older x3 entry.
    at_neg(); issue(5'd3); settle(); tick();
    at_neg(); settle(); tick();
    at_neg(); issue(5'd4); settle(); tick();
    at_neg(); clr_sgn = 1'b1; settle(); tick();
    at_neg(); settle();
    chk("flush_busy4", 32'(busy_vec[4]), 32'h0);
    chk("flush_busy3", 32'(busy_vec[3]), 32'h1);
    tick();
    at_neg(); commit(5'd3, 32'h33); settle(); tick();
    at_neg(); settle();
    chk("commit_busy3", 32'(busy_vec[3]), 32'h0);
    tick();

    // Same-cycle accept and commit of x9: data written, entry stays busy at age 0.
    at_neg(); issue(5'd9); commit(5'd9, 32'hA); settle(); tick();
    at_neg(); rd_addr1 = 5'd9; clr_sgn = 1'b1; settle();
    chk("same_cycle_data", rd_data1, 32'hA);
    chk("same_cycle_busy", 32'(busy_vec[9]), 32'h1);
    tick();
    at_neg(); settle();
    chk("age0_killed", 32'(busy_vec[9]), 32'h0);
    tick();

    // Asynchronous reset mid-stream clears everything at once.
    at_neg(); issue(5'd1); settle(); tick();
    at_neg(); issue(5'd2); settle(); tick();
    at_neg(); chk("pre_rst_busy", busy_vec, 32'h6);
    rst = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd9; settle();
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_read1", rd_data1, 32'h0);
    chk("rst_read2", rd_data2, 32'h0);
    tick();

    // Randomized traffic on a narrow address range to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      at_neg();
      rst         = ($urandom_range(0, 299) == 0);
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_we    = ($urandom_range(0, 9) < 7);
      issue_rd    = 5'($urandom_range(0, 7));
      rd_addr1    = 5'($urandom_range(0, 7));
      rd_addr2    = 5'($urandom_range(0, 31));
      clr_sgn     = ($urandom_range(0, 19) == 0);
      wb_valid    = ($urandom_range(0, 9) < 4);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
